conv_encoder_k7: RTL and testbench
==================================

Name: conv_encoder_k7

Overview:
Rate-1/2, constraint-length-7 convolutional encoder; the transmit-side counterpart of the 64-state Viterbi decoder.
- Consumes one information bit per accepted input beat.
- Emits one 2-bit code pair per bit, in the same pair bit ordering the decoder's branch-metric units consume.
- Frame-oriented: the encoder starts each frame from state 0 and terminates it so the decoder's traceback ends in state 0.

Parameters:
G0, 7'o171, generator polynomial for pair bit 0; MSB taps the current input bit.
G1, 7'o133, generator polynomial for pair bit 1; MSB taps the current input bit.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_bit  input  1  information bit
in_valid  input  1  in_bit/in_last valid
in_last  input  1  marks the final data bit of a frame
in_ready  output  1  encoder accepts input this cycle
tx_pair  output  2  code pair; [0] = G0 parity, [1] = G1 parity
out_valid  output  1  tx_pair/out_last valid
out_last  output  1  final pair of the frame
out_ready  input  1  downstream accepts pair this cycle
enc_state  output  6  current shift-register contents (debug/verification)

Behaviour:
- Reset
  - sr = 0, FSM = DATA, out_valid = 0, tx_pair = 0, out_last = 0, tail_cnt = 0.
  - Therefore enc_state = 0.
- Shift register sr[5:0]
  - sr[0] is the most recent past bit.
  - Window w[6:0] = {b, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]}, where b is the bit being encoded.
  - tx_pair[0] = ^(w & G0); tx_pair[1] = ^(w & G1).
  - Update on encode: sr <= {sr[4:0], b}.
- Output stage
  - One registered stage; latency is 1 cycle from input accept to out_valid.
  - in_ready = (FSM == DATA) && (!out_valid || out_ready); purely combinational.
  - out_valid/tx_pair/out_last hold stable while out_valid && !out_ready.
- FSM states
  - DATA:
    - On in_valid && in_ready: encode b = in_bit and register the pair.
    - If in_last: go to TAIL with tail_cnt = 0, and out_last = 0 for this pair.
  - TAIL:
    - Whenever the output stage can load (!out_valid || out_ready): encode b = 0 and increment tail_cnt.
    - On tail_cnt == 5, the pair is loaded with out_last = 1, sr reaches 0, and the FSM returns to DATA.
    - in_ready = 0 throughout TAIL.
- Frame length: a frame of N data bits produces exactly N+6 pairs, and out_last is asserted only on pair N+6.
- Back-to-back frames: the first bit of the next frame can be accepted in the same cycle the final tail pair is consumed. No bubble is required beyond the in_ready rule.
- in_valid while in TAIL: the input is ignored and not consumed; the source must hold it.
- Reset mid-frame: the partial frame is discarded, with no out_last and no tail. The encoder restarts in DATA with sr = 0.
- out_ready low indefinitely: the encoder stalls and no state changes. There is no data loss and no duplication.

Optional Feature:
CONV_ENC_TAIL_EN
- Defined: zero-tail termination exactly as above.
- Undefined:
  - The TAIL state is removed.
  - in_last is passed straight to out_last on the same data pair.
  - sr is cleared to 0 after the in_last beat is accepted, so the next frame starts in state 0.
  - A frame of N bits produces N pairs.

Decomposition:
- Shared package conv_pkg holds:
  - K = 7 and NSTATE_BITS = 6.
  - Default polynomials G0_DEF/G1_DEF.
  - Typedef pair_t (2-bit code pair).
  - FSM enum enc_state_e {DATA, TAIL}.
- These are the same constants the decoder's branch-metric and ACS blocks use.
- One natural sub-module: conv_parity, a combinational window-to-pair function instantiated once. Verification can reuse it as a golden model.

Test Plan:
- Impulse: frame {1}, in_last=1, out_ready=1 → 7 pairs tx_pair = 11, 01, 11, 11, 00, 10, 11. out_last only on the 7th pair; enc_state = 0 afterwards.
- All-zero frame of 8 bits → 14 pairs of 00; out_last on the 14th pair.
- Backpressure: random out_ready (50%) on a 32-bit random frame → pair stream identical to the out_ready=1 run. tx_pair is stable while stalled, and in_ready = 0 during the 6 tail cycles.
- Back-to-back frames {1},{1} with in_valid held high → 14 pairs equal to the impulse sequence twice. Second frame's first beat is accepted in the cycle the first frame's out_last pair is consumed.
- Reset mid-frame after 3 bits of {1,1,1,...}, then frame {1} → after reset out_valid=0 and enc_state=0; output is exactly the impulse sequence.
- CONV_ENC_TAIL_EN undefined: frame {1,0,1} → pairs 11, 01, 00; out_last on the 3rd pair; enc_state = 0 afterwards.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Constants and types shared by the K=7 rate-1/2 convolutional encoder and the
// matching 64-state Viterbi decoder (branch-metric and ACS blocks).
//
// Contents:
//   K, NSTATE_BITS     constraint length and shift-register width
//   G0_DEF, G1_DEF     default generator polynomials (octal 171 / 133)
//   pair_t             2-bit code pair, [0] = G0 parity, [1] = G1 parity
//   enc_state_e        encoder frame FSM {DATA, TAIL}
//   tail_cnt_t         counter type for the zero-tail flush
//   TAIL_LAST          value of the tail counter on the final flush beat
// -----------------------------------------------------------------------------
package conv_pkg;

   localparam int K           = 7;
   localparam int NSTATE_BITS = K - 1;

   // The MSB of each polynomial taps the bit currently being encoded.
   localparam logic [K-1:0] G0_DEF = 7'o171;
   localparam logic [K-1:0] G1_DEF = 7'o133;

   typedef logic [1:0] pair_t;

   typedef enum logic {
      DATA = 1'b0,
      TAIL = 1'b1
   } enc_state_e;

   typedef logic [2:0] tail_cnt_t;

   // NSTATE_BITS zero bits flush the register; counting starts at 0.
   localparam tail_cnt_t TAIL_LAST = tail_cnt_t'(NSTATE_BITS - 1);

endpackage

// File: rtl/conv_parity.sv
// -----------------------------------------------------------------------------
// conv_parity
// Combinational window-to-pair function of the rate-1/2 K=7 code.
//
// Ports:
//   window [K-1:0]  in   {b, sr[0], sr[1], ..., sr[5]}; MSB is the bit being
//                        encoded, then the past bits from newest to oldest
//   pair   [1:0]    out  [0] = parity of window & G0, [1] = parity of window & G1
// -----------------------------------------------------------------------------
module conv_parity
   import conv_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic [K-1:0] window,
   output logic [1:0]   pair
);

   assign pair[0] = ^(window & G0);
   assign pair[1] = ^(window & G1);

endmodule

// File: rtl/conv_encoder_k7.sv
// -----------------------------------------------------------------------------
// conv_encoder_k7
// Rate-1/2, constraint-length-7 convolutional encoder, frame oriented. Every
// frame starts from state 0. With CONV_ENC_TAIL_EN defined, each frame is
// terminated by six zero tail bits so the decoder traceback ends in state 0;
// without it, in_last is forwarded onto the last data pair and the register is
// cleared after that beat.
//
// Build option: CONV_ENC_TAIL_EN (define to enable zero-tail termination).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_bit     in   information bit
//   in_valid   in   in_bit / in_last valid
//   in_last    in   final data bit of a frame
//   in_ready   out  encoder accepts input this cycle (combinational)
//   tx_pair    out  code pair, [0] = G0 parity, [1] = G1 parity
//   out_valid  out  tx_pair / out_last valid
//   out_last   out  final pair of the frame
//   out_ready  in   downstream accepts the pair this cycle
//   enc_state  out  shift-register contents, sr[0] = most recent past bit
//
// Handshake: a beat transfers on a rising edge where valid && ready. Once
// out_valid is high, tx_pair/out_last/out_valid stay stable until out_ready;
// the input side is never consumed unless in_ready is high, so a source held
// off (including during the tail) simply keeps its beat.
// -----------------------------------------------------------------------------
module conv_encoder_k7
   import conv_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_bit,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [1:0]             tx_pair,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic [NSTATE_BITS-1:0] enc_state
);

   logic [NSTATE_BITS-1:0] sr;
   logic [K-1:0]           window;
   logic [1:0]             pair_next;
   logic                   enc_bit;
   logic                   load;
   logic                   encode_en;

   // The single output register may be (re)loaded when empty or being drained.
   assign load = !out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
   enc_state_e fsm;
   tail_cnt_t  tail_cnt;

   assign in_ready  = (fsm == DATA) && load;
   // Tail beats push zeros without consuming any input.
   assign enc_bit   = (fsm == TAIL) ? 1'b0 : in_bit;
   assign encode_en = (fsm == DATA) ? (in_valid && load) : load;
`else
   assign in_ready  = load;
   assign enc_bit   = in_bit;
   assign encode_en = in_valid && load;
`endif

   // Window order: current bit first, then past bits newest to oldest.
   always_comb begin
      window        = '0;
      window[K-1]   = enc_bit;
      for (int i = 0; i < NSTATE_BITS; i++) begin
         window[K-2-i] = sr[i];
      end
   end

   conv_parity #(
      .G0 (G0),
      .G1 (G1)
   ) u_parity (
      .window (window),
      .pair   (pair_next)
   );

`ifdef CONV_ENC_TAIL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         fsm       <= DATA;
         tail_cnt  <= '0;
         out_valid <= 1'b0;
         tx_pair   <= '0;
         out_last  <= 1'b0;
      end else if (encode_en) begin
         out_valid <= 1'b1;
         tx_pair   <= pair_next;
         sr        <= {sr[NSTATE_BITS-2:0], enc_bit};
         case (fsm)
            DATA: begin
               out_last <= 1'b0;
               if (in_last) begin
                  fsm      <= TAIL;
                  tail_cnt <= '0;
               end
            end
            TAIL: begin
               // Sixth zero shifted in: register is back at 0, frame closed.
               if (tail_cnt == TAIL_LAST) begin
                  out_last <= 1'b1;
                  fsm      <= DATA;
                  tail_cnt <= '0;
               end else begin
                  out_last <= 1'b0;
                  tail_cnt <= tail_cnt + tail_cnt_t'(1);
               end
            end
            default: begin
               fsm <= DATA;
            end
         endcase
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         out_valid <= 1'b0;
         tx_pair   <= '0;
         out_last  <= 1'b0;
      end else if (encode_en) begin
         out_valid <= 1'b1;
         tx_pair   <= pair_next;
         out_last  <= in_last;
         // Without a tail, clear the register so the next frame starts at 0.
         sr        <= in_last ? '0 : {sr[NSTATE_BITS-2:0], enc_bit};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

   assign enc_state = sr;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_k7
// Self-checking bench for conv_encoder_k7. The reference treats the code as a
// convolution of the frame's bit sequence with the two generator polynomials.
// Build option: CONV_ENC_TAIL_EN selects the zero-tail expectations.
// -----------------------------------------------------------------------------
module tb_conv_encoder_k7;

`ifdef CONV_ENC_TAIL_EN
   localparam int TAIL_N = 6;
`else
   localparam int TAIL_N = 0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [1:0] tx_pair;
   logic       out_valid;
   logic       out_last;
   logic       out_ready = 1'b1;
   logic [5:0] enc_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   conv_encoder_k7 dut (
      .clk       (clk),
      .rst       (rst),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .tx_pair   (tx_pair),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .enc_state (enc_state)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] g0_m = 7'o171;
   logic [6:0] g1_m = 7'o133;
   logic       hist[$];          // bits of the current frame, oldest first
   logic [2:0] exp_q[$];         // {last, pair}
   logic [1:0] cap_q[$];         // pairs actually consumed
   logic       tail_window = 1'b0;
   logic       rand_ready = 1'b0;
   int         acc_cyc = -1;
   int         last_cons_cyc = -1;

   // Pair for position idx of the frame: convolution over the last 7 bits.
   function automatic logic [1:0] model_pair(input int idx);
      logic p0, p1;
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < 7; j++) begin
         if (idx - j >= 0 && hist[idx-j]) begin
            p0 ^= g0_m[6-j];
            p1 ^= g1_m[6-j];
         end
      end
      return {p1, p0};
   endfunction

   task automatic model_push(input logic b, input logic last);
      logic [1:0] pr;
      hist.push_back(b);
      pr = model_pair(hist.size() - 1);
      exp_q.push_back({last && (TAIL_N == 0), pr});
      if (last) begin
         for (int t = 0; t < TAIL_N; t++) begin
            hist.push_back(1'b0);
            pr = model_pair(hist.size() - 1);
            exp_q.push_back({(t == TAIL_N - 1), pr});
         end
         hist.delete();
      end
   endtask

   // ---------------- downstream ready ----------------
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- compare process ----------------
   logic       stall_pending = 1'b0;
   logic [2:0] held = '0;

   always @(negedge clk) begin
      if (rst) begin
         stall_pending = 1'b0;
      end else begin
         if (stall_pending)
            check("stall_hold", int'({out_valid, out_last, tx_pair}), int'({1'b1, held}));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("pair_expected", 0, 1);
            end else begin
               check("pair", int'({out_last, tx_pair}), int'(exp_q.pop_front()));
            end
            cap_q.push_back(tx_pair);
            if (out_last) begin
               last_cons_cyc = cyc;
               tail_window   = 1'b0;
            end
         end
         check("in_ready", int'(in_ready), int'(!tail_window && (!out_valid || out_ready)));
         stall_pending = out_valid && !out_ready;
         held          = {out_last, tx_pair};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic b, input logic last);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = last;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) acc_cyc = cyc;
         @(posedge clk);
         if (acc) begin
            model_push(b, last);
            if (last && TAIL_N != 0) tail_window = 1'b1;
         end
         #1;
         n++;
      end
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic idle_input();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_enc_state", int'(enc_state), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle_input();
      exp_q.delete();
      hist.delete();
      tail_window = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_enc_state", int'(enc_state), 0);
      check("rst_tx_pair", int'(tx_pair), 0);
      check("rst_out_last", int'(out_last), 0);
      rst = 1'b0;
   endtask

   // ---------------- literal expectations ----------------
   logic [1:0] imp_lit[7] = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
   logic [1:0] s101_lit[3] = '{2'd3, 2'd1, 2'd0};

   task automatic check_impulse(input string name, input int base);
      for (int i = 0; i < 1 + TAIL_N; i++)
         check(name, int'(cap_q[base+i]), int'(imp_lit[i]));
   endtask

   // ---------------- main sequence ----------------
   logic [1:0] ref_q[$];
   logic [31:0] rnd;
   int nz;

   initial begin
      do_reset();
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // Impulse frame {1}
      cap_q.delete();
      send_bit(1'b1, 1'b1);
      idle_input();
      drain();
      check("impulse_len", cap_q.size(), 1 + TAIL_N);
      if (cap_q.size() == 1 + TAIL_N) check_impulse("impulse_pair", 0);

      // All-zero frame of 8 bits
      cap_q.delete();
      for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7);
      idle_input();
      drain();
      check("zero_len", cap_q.size(), 8 + TAIL_N);
      nz = 0;
      foreach (cap_q[i]) if (cap_q[i] != 2'b00) nz++;
      check("zero_pairs", nz, 0);

      // Frame {1,0,1}
      cap_q.delete();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      idle_input();
      drain();
      check("s101_len", cap_q.size(), 3 + TAIL_N);
      if (cap_q.size() >= 3)
         for (int i = 0; i < 3; i++) check("s101_pair", int'(cap_q[i]), int'(s101_lit[i]));

      // 32-bit random frame, first with out_ready=1, then with backpressure
      rnd = $urandom();
      cap_q.delete();
      for (int i = 0; i < 32; i++) send_bit(rnd[i], i == 31);
      idle_input();
      drain();
      ref_q = cap_q;
      cap_q.delete();
      rand_ready = 1'b1;
      for (int i = 0; i < 32; i++) send_bit(rnd[i], i == 31);
      idle_input();
      drain();
      rand_ready = 1'b0;
      check("bp_len", cap_q.size(), 32 + TAIL_N);
      if (cap_q.size() == ref_q.size()) begin
         nz = 0;
         foreach (cap_q[i]) if (cap_q[i] != ref_q[i]) nz++;
         check("bp_stream", nz, 0);
      end

      // Back-to-back frames {1},{1}, in_valid held high between them
      @(posedge clk);
      #1;
      cap_q.delete();
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      check("b2b_accept_cycle", acc_cyc, last_cons_cyc);
      idle_input();
      drain();
      check("b2b_len", cap_q.size(), 2 * (1 + TAIL_N));
      if (cap_q.size() == 2 * (1 + TAIL_N)) begin
         check_impulse("b2b_first", 0);
         check_impulse("b2b_second", 1 + TAIL_N);
      end

      // Reset in the middle of a frame, then an impulse frame
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      idle_input();
      do_reset();
      cap_q.delete();
      send_bit(1'b1, 1'b1);
      idle_input();
      drain();
      check("after_rst_len", cap_q.size(), 1 + TAIL_N);
      if (cap_q.size() == 1 + TAIL_N) check_impulse("after_rst_pair", 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
